// File: rtl/ita_hwpe_seq_ctrl.sv
// ita_hwpe_seq_ctrl: streamer sequencer for the ITA HWPE.
// Launches input/bias/output streamers on start, then restarts the weight
// source once per configured base pointer, and finally waits for the drain
// condition before signalling done/clear.
// Optional drain watchdog: define ITA_SEQ_TIMEOUT_EN.
module ita_hwpe_seq_ctrl #(
  parameter int unsigned N_PTR          = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned M              = 64,
  parameter int unsigned N              = 16,
  parameter int unsigned N_FIFO         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned NL_W          = $clog2(N_PTR + 1),
  localparam int unsigned IDX_W         = (N_PTR > 1) ? $clog2(N_PTR) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [NL_W-1:0]         n_loads_i,
  input  logic                    weight_preload_i,
  input  logic                    bias_disable_i,
  input  logic                    output_disable_i,
  input  logic [N_PTR*ADDR_W-1:0] weight_ptr_i,
  input  logic                    weight_done_i,
  input  logic                    input_ready_i,
  input  logic                    weight_ready_i,
  input  logic                    bias_ready_i,
  input  logic                    output_ready_i,
  input  logic                    engine_busy_i,
  input  logic [N_FIFO-1:0]       fifo_empty_i,
  output logic                    input_req_start_o,
  output logic                    bias_req_start_o,
  output logic                    output_req_start_o,
  output logic                    weight_req_start_o,
  output logic [ADDR_W-1:0]       weight_base_addr_o,
  output logic [LEN_W-1:0]        weight_len_o,
  output logic [IDX_W-1:0]        load_idx_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    clear_o,
  output logic                    timeout_o
);

  localparam int unsigned TOT_LEN = M * M / N;
  localparam logic [LEN_W-1:0]  LEN_PRE   = LEN_W'(TOT_LEN / 8);
  localparam logic [LEN_W-1:0]  LEN_NOPRE = LEN_W'(TOT_LEN / 8 - M / 8);
  localparam logic [LEN_W-1:0]  LEN_NEXT  = LEN_W'(M / 8);
  localparam logic [ADDR_W-1:0] SKIP_OFS  = ADDR_W'(N * M);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t             r_state, w_nextState;
  logic [ADDR_W-1:0]  r_ptr [N_PTR];
  logic [ADDR_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_idx, r_last, w_last, w_nextIdx;
  logic               r_outDis;
  logic               r_weightStart;
  logic [1:0]         r_mask;
  logic               w_launch, w_advance, w_drainCond, w_drainOk;
  logic               w_inStart, w_biasStart, w_outStart, w_done, w_clear;

  assign w_nextIdx = r_idx + IDX_W'(1);

  // Clamp the requested load count into a last-index in [0, N_PTR-1]
  always_comb begin
    w_last = '0;
    if (n_loads_i == '0) begin
      w_last = '0;
    end else if (n_loads_i > NL_W'(N_PTR)) begin
      w_last = IDX_W'(N_PTR - 1);
    end else begin
      w_last = IDX_W'(n_loads_i - NL_W'(1));
    end
  end

  // Drain is masked while the last restart pulse and its ready latency settle
  always_comb begin
    w_drainCond = r_outDis ? (!engine_busy_i && input_ready_i && weight_ready_i && bias_ready_i)
                           : (output_ready_i && weight_ready_i && (&fifo_empty_i));
    w_drainOk   = w_drainCond && !r_weightStart && (r_mask == 2'd0);
  end

`ifdef ITA_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_toCnt;
  logic             w_timeout;

  // Watchdog counts cycles spent in DRAIN, cleared whenever outside it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_toCnt <= '0;
    end else if (r_state != DRAIN) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + CNT_W'(1);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and pulse decode
  always_comb begin
    w_nextState = r_state;
    w_launch    = 1'b0;
    w_advance   = 1'b0;
    w_inStart   = 1'b0;
    w_biasStart = 1'b0;
    w_outStart  = 1'b0;
    w_done      = 1'b0;
    w_clear     = 1'b0;
`ifdef ITA_SEQ_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_launch    = 1'b1;
          w_inStart   = 1'b1;
          w_biasStart = !bias_disable_i;
          w_outStart  = !output_disable_i;
          w_nextState = (w_last != '0) ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        if (weight_done_i && !r_weightStart) begin
          w_advance = 1'b1;
          if (w_nextIdx == r_last) begin
            w_nextState = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_drainOk) begin
          w_done      = 1'b1;
          w_clear     = 1'b1;
          w_nextState = IDLE;
        end
`ifdef ITA_SEQ_TIMEOUT_EN
        else if (r_toCnt == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout   = 1'b1;
          w_done      = 1'b1;
          w_clear     = 1'b1;
          w_nextState = IDLE;
        end
`endif
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Latch configuration at start and step the weight address/length per load
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_last        <= '0;
      r_outDis      <= 1'b0;
      r_weightStart <= 1'b0;
      r_mask        <= 2'd0;
      for (int k = 0; k < int'(N_PTR); k++) begin
        r_ptr[k] <= '0;
      end
    end else begin
      r_weightStart <= w_launch || w_advance;
      if (r_weightStart) begin
        r_mask <= 2'd2;
      end else if (r_mask != 2'd0) begin
        r_mask <= r_mask - 2'd1;
      end
      if (w_launch) begin
        r_idx    <= '0;
        r_last   <= w_last;
        r_outDis <= output_disable_i;
        r_len    <= weight_preload_i ? LEN_PRE : LEN_NOPRE;
        r_base   <= weight_ptr_i[ADDR_W-1:0] + (weight_preload_i ? '0 : SKIP_OFS);
        for (int k = 0; k < int'(N_PTR); k++) begin
          r_ptr[k] <= weight_ptr_i[k*ADDR_W +: ADDR_W];
        end
      end else if (w_advance) begin
        r_idx  <= w_nextIdx;
        r_len  <= LEN_NEXT;
        r_base <= r_ptr[w_nextIdx];
      end
    end
  end

  assign input_req_start_o  = w_inStart;
  assign bias_req_start_o   = w_biasStart;
  assign output_req_start_o = w_outStart;
  assign weight_req_start_o = r_weightStart;
  assign weight_base_addr_o = r_base;
  assign weight_len_o       = r_len;
  assign load_idx_o         = r_idx;
  assign busy_o             = (r_state != IDLE);
  assign done_o             = w_done;
  assign clear_o            = w_clear;
`ifdef ITA_SEQ_TIMEOUT_EN
  assign timeout_o          = w_timeout;
`else
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_ita_hwpe_seq_ctrl.sv
// Testbench for ita_hwpe_seq_ctrl: directed and randomized transactions
// checked against a transaction-level reference of the load sequence.
module tb_ita_hwpe_seq_ctrl;

  localparam int N_PTR  = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int M      = 64;
  localparam int N      = 16;
  localparam int N_FIFO = 2;
  localparam int NL_W   = $clog2(N_PTR + 1);
  localparam int IDX_W  = (N_PTR > 1) ? $clog2(N_PTR) : 1;

  logic                    clk_i;
  logic                    rst_ni;
  logic                    start_i;
  logic [NL_W-1:0]         n_loads_i;
  logic                    weight_preload_i;
  logic                    bias_disable_i;
  logic                    output_disable_i;
  logic [N_PTR*ADDR_W-1:0] weight_ptr_i;
  logic                    weight_done_i;
  logic                    input_ready_i;
  logic                    weight_ready_i;
  logic                    bias_ready_i;
  logic                    output_ready_i;
  logic                    engine_busy_i;
  logic [N_FIFO-1:0]       fifo_empty_i;
  logic                    input_req_start_o;
  logic                    bias_req_start_o;
  logic                    output_req_start_o;
  logic                    weight_req_start_o;
  logic [ADDR_W-1:0]       weight_base_addr_o;
  logic [LEN_W-1:0]        weight_len_o;
  logic [IDX_W-1:0]        load_idx_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    clear_o;
  logic                    timeout_o;

  int compared   = 0;
  int mismatched = 0;

  ita_hwpe_seq_ctrl #(
    .N_PTR(N_PTR), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .M(M), .N(N), .N_FIFO(N_FIFO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .n_loads_i(n_loads_i),
    .weight_preload_i(weight_preload_i), .bias_disable_i(bias_disable_i),
    .output_disable_i(output_disable_i), .weight_ptr_i(weight_ptr_i),
    .weight_done_i(weight_done_i), .input_ready_i(input_ready_i),
    .weight_ready_i(weight_ready_i), .bias_ready_i(bias_ready_i),
    .output_ready_i(output_ready_i), .engine_busy_i(engine_busy_i),
    .fifo_empty_i(fifo_empty_i), .input_req_start_o(input_req_start_o),
    .bias_req_start_o(bias_req_start_o), .output_req_start_o(output_req_start_o),
    .weight_req_start_o(weight_req_start_o), .weight_base_addr_o(weight_base_addr_o),
    .weight_len_o(weight_len_o), .load_idx_o(load_idx_o), .busy_o(busy_o),
    .done_o(done_o), .clear_o(clear_o), .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReadyInputs();
    start_i        = 1'b0;
    weight_done_i  = 1'b0;
    input_ready_i  = 1'b1;
    weight_ready_i = 1'b1;
    bias_ready_i   = 1'b1;
    output_ready_i = 1'b1;
    engine_busy_i  = 1'b0;
    fifo_empty_i   = '1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_clear"}, clear_o, 0);
    checkOutput({tag, "_wreq"}, weight_req_start_o, 0);
    checkOutput({tag, "_base"}, weight_base_addr_o, 0);
    checkOutput({tag, "_len"}, weight_len_o, 0);
    checkOutput({tag, "_idx"}, load_idx_o, 0);
    checkOutput({tag, "_timeout"}, timeout_o, 0);
  endtask

  // One full transaction; abortIdx>=0 applies reset right after that load's restart
  task automatic applyStimulus(input int n, input bit pre, input bit bd, input bit od,
                               input int hold, input logic [ADDR_W-1:0] ptrBase, input int abortIdx);
    logic [ADDR_W-1:0] ptrs    [N_PTR];
    logic [ADDR_W-1:0] expBase [N_PTR];
    logic [LEN_W-1:0]  expLen  [N_PTR];
    int  nEff;
    int  mode;
    bit  blocked;
    bit  cond;
    bit  expDone;
    for (int k = 0; k < N_PTR; k++) begin
      ptrs[k] = (ptrBase != 0) ? ptrBase + ADDR_W'(k * 32'h1000) : ADDR_W'($urandom);
    end
    nEff = (n == 0) ? 1 : ((n > N_PTR) ? N_PTR : n);
    for (int k = 0; k < N_PTR; k++) begin
      expBase[k] = ptrs[k];
      expLen[k]  = LEN_W'(M / 8);
    end
    if (pre) begin
      expLen[0] = LEN_W'((M * M / N) / 8);
    end else begin
      expLen[0]  = LEN_W'((M * M / N) / 8 - M / 8);
      expBase[0] = ptrs[0] + ADDR_W'(N * M);
    end
    mode = $urandom_range(0, 2);

    @(negedge clk_i);
    setReadyInputs();
    start_i          = 1'b1;
    n_loads_i        = NL_W'(n);
    weight_preload_i = pre;
    bias_disable_i   = bd;
    output_disable_i = od;
    for (int k = 0; k < N_PTR; k++) weight_ptr_i[k*ADDR_W +: ADDR_W] = ptrs[k];
    #2;
    checkOutput("in_start", input_req_start_o, 1);
    checkOutput("bias_start", bias_req_start_o, !bd);
    checkOutput("out_start", output_req_start_o, !od);
    checkOutput("wreq_early", weight_req_start_o, 0);

    @(negedge clk_i);
    start_i          = 1'b0;
    n_loads_i        = NL_W'($urandom);
    weight_preload_i = 1'($urandom);
    bias_disable_i   = 1'($urandom);
    output_disable_i = 1'($urandom);
    weight_ptr_i     = {$urandom, $urandom, $urandom, $urandom};
    weight_done_i    = 1'($urandom_range(0, 1));
    #2;
    checkOutput("wreq_0", weight_req_start_o, 1);
    checkOutput("base_0", weight_base_addr_o, expBase[0]);
    checkOutput("len_0", weight_len_o, expLen[0]);
    checkOutput("idx_0", load_idx_o, 0);
    checkOutput("busy", busy_o, 1);

    for (int k = 1; k < nEff; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk_i);
        weight_done_i = 1'b0;
        start_i       = 1'($urandom_range(0, 1));
        #2;
        checkOutput("gap_wreq", weight_req_start_o, 0);
        checkOutput("gap_idx", load_idx_o, k - 1);
        checkOutput("gap_done", done_o, 0);
        checkOutput("gap_instart", input_req_start_o, 0);
      end
      @(negedge clk_i);
      weight_done_i = 1'b1;
      start_i       = 1'($urandom_range(0, 1));
      #2;
      checkOutput("wdone_wreq", weight_req_start_o, 0);
      checkOutput("wdone_done", done_o, 0);
      @(negedge clk_i);
      weight_done_i = 1'($urandom_range(0, 1));
      start_i       = 1'b0;
      #2;
      checkOutput("wreq_k", weight_req_start_o, 1);
      checkOutput("base_k", weight_base_addr_o, expBase[k]);
      checkOutput("len_k", weight_len_o, expLen[k]);
      checkOutput("idx_k", load_idx_o, k);
      if (k == abortIdx) begin
        @(negedge clk_i);
        rst_ni = 1'b0;
        setReadyInputs();
        #2;
        checkAllZero("rst_mid");
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) begin
          @(negedge clk_i);
          #2;
          checkOutput("post_rst_done", done_o, 0);
          checkOutput("post_rst_busy", busy_o, 0);
          checkOutput("post_rst_wreq", weight_req_start_o, 0);
        end
        return;
      end
    end

    for (int c = 1; c <= 64; c++) begin
      @(negedge clk_i);
      setReadyInputs();
      weight_done_i = 1'($urandom_range(0, 1));
      start_i       = 1'($urandom_range(0, 1));
      blocked       = (c <= hold);
      if (od) begin
        output_ready_i = 1'($urandom_range(0, 1));
        fifo_empty_i   = N_FIFO'($urandom);
        if (blocked) begin
          case (mode)
            0:       engine_busy_i = 1'b1;
            1:       input_ready_i = 1'b0;
            default: bias_ready_i  = 1'b0;
          endcase
        end
      end else begin
        engine_busy_i = 1'($urandom_range(0, 1));
        input_ready_i = 1'($urandom_range(0, 1));
        bias_ready_i  = 1'($urandom_range(0, 1));
        if (blocked) begin
          case (mode)
            0:       output_ready_i = 1'b0;
            1:       weight_ready_i = 1'b0;
            default: fifo_empty_i[$urandom_range(0, N_FIFO - 1)] = 1'b0;
          endcase
        end
      end
      cond = od ? (!engine_busy_i && input_ready_i && weight_ready_i && bias_ready_i)
                : (output_ready_i && weight_ready_i && (&fifo_empty_i));
      expDone = cond && (c >= 3);
      #2;
      checkOutput("drain_done", done_o, expDone);
      checkOutput("drain_clear", clear_o, expDone);
      checkOutput("drain_timeout", timeout_o, 0);
      checkOutput("drain_instart", input_req_start_o, 0);
      checkOutput("drain_wreq", weight_req_start_o, 0);
      if (expDone) break;
    end

    @(negedge clk_i);
    setReadyInputs();
    #2;
    checkOutput("end_busy", busy_o, 0);
    checkOutput("end_done", done_o, 0);
  endtask

  initial begin
    rst_ni           = 1'b0;
    n_loads_i        = '0;
    weight_preload_i = 1'b0;
    bias_disable_i   = 1'b0;
    output_disable_i = 1'b0;
    weight_ptr_i     = '0;
    setReadyInputs();
    #2;
    checkAllZero("reset");
    checkOutput("reset_instart", input_req_start_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #2;
    checkAllZero("idle");

    $display("[TB] single load, preload");
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 0, 32'h1000, -1);
    $display("[TB] single load, no preload");
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 0, 32'h1000, -1);
    $display("[TB] four loads");
    applyStimulus(4, 1'b1, 1'b0, 1'b0, 0, 32'h1000, -1);
    $display("[TB] n=0 and n=7 clamping");
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 0, 32'h1000, -1);
    applyStimulus(7, 1'b0, 1'b0, 1'b0, 2, 32'h1000, -1);
    $display("[TB] engine-based drain with busy held");
    applyStimulus(2, 1'b1, 1'b1, 1'b1, 10, 32'h1000, -1);
    $display("[TB] address wrap");
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 0, 32'hFFFF_FF00, -1);
    $display("[TB] reset mid-load");
    applyStimulus(3, 1'b1, 1'b0, 1'b0, 0, 32'h1000, 1);
    $display("[TB] randomized transactions");
    for (int t = 0; t < 25; t++) begin
      applyStimulus($urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 8), '0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
